// File: rtl/audio_sample_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : audio_sample_fifo
//  Purpose  : Stereo PCM pair FIFO between the I2S receiver strobe and a
//             valid/ready audio consumer. First-word-fall-through output,
//             mono downmix of the head pair, sticky overflow on dropped pairs.
//  Revision : 1.0 - initial release
// ============================================================================
module audio_sample_fifo #(
  parameter int SAMPLE_WIDTH = 16,
  parameter int DEPTH        = 16
) (
  input  logic                        clock_in,
  input  logic                        reset_in,
  input  logic [SAMPLE_WIDTH-1:0]     left_sample_in,
  input  logic [SAMPLE_WIDTH-1:0]     right_sample_in,
  input  logic                        new_sample_in,
  output logic [SAMPLE_WIDTH-1:0]     left_sample_out,
  output logic [SAMPLE_WIDTH-1:0]     right_sample_out,
  output logic [SAMPLE_WIDTH-1:0]     mono_sample_out,
  output logic                        sample_valid_out,
  input  logic                        sample_ready_in,
  output logic [$clog2(DEPTH):0]      fill_level_out,
  output logic                        overflow_out,
  input  logic                        clear_overflow_in
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam logic [ADDR_W:0] PTR_ONE = 1;

  // Pair storage; contents are don't-care after reset, so no reset here.
  logic [SAMPLE_WIDTH-1:0] left_mem_q  [DEPTH];
  logic [SAMPLE_WIDTH-1:0] right_mem_q [DEPTH];

  // Pointers carry an extra wrap bit to tell full from empty.
  logic [ADDR_W:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0] fill_q,   fill_d;
  logic            overflow_q, overflow_d;

  logic w_empty;
  logic w_full;
  logic w_pop;
  logic w_push;
  logic w_drop;

  logic [SAMPLE_WIDTH-1:0] w_head_left;
  logic [SAMPLE_WIDTH-1:0] w_head_right;

  assign w_empty = (wr_ptr_q == rd_ptr_q);
  assign w_full  = (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]) &&
                   (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]);

  // A pop frees a slot on the same edge, so a full FIFO still accepts a
  // strobe when the consumer takes the head pair at that edge.
  assign w_pop  = !w_empty && sample_ready_in;
  assign w_push = new_sample_in && (!w_full || w_pop);
  assign w_drop = new_sample_in && w_full && !w_pop;

  // Next-state computation for pointers, fill level and sticky overflow.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    fill_d     = fill_q;
    overflow_d = overflow_q;

    if (w_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (w_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;

    unique case ({w_push, w_pop})
      2'b10:   fill_d = fill_q + PTR_ONE;
      2'b01:   fill_d = fill_q - PTR_ONE;
      default: fill_d = fill_q;
    endcase

    // A drop outranks a clear on the same edge.
    if (w_drop)                 overflow_d = 1'b1;
    else if (clear_overflow_in) overflow_d = 1'b0;
  end

  // Control state with asynchronous active-low reset.
  always_ff @(posedge clock_in or negedge reset_in) begin
    if (!reset_in) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fill_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      fill_q     <= fill_d;
      overflow_q <= overflow_d;
    end
  end

  // Store the incoming pair at the write slot on an accepted strobe.
  always_ff @(posedge clock_in) begin
    if (w_push) begin
      left_mem_q[wr_ptr_q[ADDR_W-1:0]]  <= left_sample_in;
      right_mem_q[wr_ptr_q[ADDR_W-1:0]] <= right_sample_in;
    end
  end

  // Head pair is read combinationally and forced to zero while empty.
  assign w_head_left  = w_empty ? '0 : left_mem_q[rd_ptr_q[ADDR_W-1:0]];
  assign w_head_right = w_empty ? '0 : right_mem_q[rd_ptr_q[ADDR_W-1:0]];

  assign left_sample_out  = w_head_left;
  assign right_sample_out = w_head_right;
  assign sample_valid_out = !w_empty;
  assign fill_level_out   = fill_q;
  assign overflow_out     = overflow_q;

  // floor((L+R)/2) computed as (L>>>1) + (R>>>1) + (L[0]&R[0]); the result
  // always fits in SAMPLE_WIDTH bits, so no wider intermediate is needed.
  assign mono_sample_out =
      {w_head_left[SAMPLE_WIDTH-1],  w_head_left[SAMPLE_WIDTH-1:1]}  +
      {w_head_right[SAMPLE_WIDTH-1], w_head_right[SAMPLE_WIDTH-1:1]} +
      {{(SAMPLE_WIDTH-1){1'b0}}, w_head_left[0] & w_head_right[0]};

endmodule
`default_nettype wire

// File: tb/tb_audio_sample_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : tb_audio_sample_fifo
//  Purpose  : Self-checking bench for audio_sample_fifo against a queue model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_audio_sample_fifo;

  localparam int SW    = 16;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [SW-1:0] l_in = '0, r_in = '0;
  logic          strobe = 1'b0, ready = 1'b0, clr = 1'b0;
  logic [SW-1:0] l_out, r_out, m_out;
  logic          valid_out, ovf_out;
  logic [4:0]    fill_out;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model: queue of {left,right} pairs plus sticky overflow bit.
  logic [2*SW-1:0] mq[$];
  logic            m_ovf = 1'b0;

  audio_sample_fifo #(.SAMPLE_WIDTH(SW), .DEPTH(DEPTH)) dut (
    .clock_in          (clk),
    .reset_in          (rst_n),
    .left_sample_in    (l_in),
    .right_sample_in   (r_in),
    .new_sample_in     (strobe),
    .left_sample_out   (l_out),
    .right_sample_out  (r_out),
    .mono_sample_out   (m_out),
    .sample_valid_out  (valid_out),
    .sample_ready_in   (ready),
    .fill_level_out    (fill_out),
    .overflow_out      (ovf_out),
    .clear_overflow_in (clr)
  );

  always #5 clk = ~clk;

  function automatic logic [SW-1:0] ref_mono(logic [SW-1:0] l, logic [SW-1:0] r);
    int s;
    s = $signed(l) + $signed(r);
    s = s >>> 1;
    return s[SW-1:0];
  endfunction

  function automatic logic [SW-1:0] exp_l();
    logic [2*SW-1:0] p;
    if (mq.size() == 0) return '0;
    p = mq[0];
    return p[2*SW-1:SW];
  endfunction

  function automatic logic [SW-1:0] exp_r();
    logic [2*SW-1:0] p;
    if (mq.size() == 0) return '0;
    p = mq[0];
    return p[SW-1:0];
  endfunction

  // Advance one clock edge and apply the same edge to the model.
  task automatic tick();
    logic do_pop;
    @(posedge clk);
    if (!rst_n) begin
      mq.delete();
      m_ovf = 1'b0;
    end else begin
      do_pop = (mq.size() != 0) && ready;
      if (strobe && mq.size() == DEPTH && !do_pop) m_ovf = 1'b1;
      else if (clr) m_ovf = 1'b0;
      if (do_pop) void'(mq.pop_front());
      if (strobe && mq.size() < DEPTH) mq.push_back({l_in, r_in});
    end
    #1;
  endtask

  task automatic idle_inputs();
    strobe = 1'b0; ready = 1'b0; clr = 1'b0; l_in = '0; r_in = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    tick(); tick();
    #2 rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    tick(); tick();
    n_cmp++;
    if (valid_out !== 1'b0 || fill_out !== 5'd0 || ovf_out !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: valid=%b fill=%0d ovf=%b required 0/0/0", valid_out, fill_out, ovf_out);
    end
    n_cmp++;
    if (l_out !== '0 || r_out !== '0 || m_out !== '0) begin
      n_fail++;
      $display("FAIL reset_data: l=%h r=%h m=%h required 0", l_out, r_out, m_out);
    end
    #2 rst_n = 1'b1;
    tick();
  endtask

  task automatic test_latency();
    l_in = 16'h1234; r_in = 16'h8000; strobe = 1'b1; ready = 1'b0;
    #1;
    n_cmp++;
    if (valid_out !== 1'b0) begin
      n_fail++;
      $display("FAIL no_bypass: valid=%b required 0", valid_out);
    end
    tick();
    idle_inputs();
    n_cmp++;
    if (valid_out !== 1'b1 || fill_out !== 5'd1 || m_out !== 16'hC91A) begin
      n_fail++;
      $display("FAIL first_pair: valid=%b fill=%0d mono=%h required 1/1/c91a", valid_out, fill_out, m_out);
    end
    n_cmp++;
    if (l_out !== 16'h1234 || r_out !== 16'h8000 || m_out !== ref_mono(l_out, r_out)) begin
      n_fail++;
      $display("FAIL first_data: l=%h r=%h required 1234/8000", l_out, r_out);
    end
  endtask

  task automatic test_fill_overflow_drain();
    do_reset();
    for (int i = 0; i < DEPTH + 1; i++) begin
      l_in = SW'(i); r_in = SW'(-i); strobe = 1'b1;
      tick();
    end
    idle_inputs();
    n_cmp++;
    if (fill_out !== 5'd16 || ovf_out !== 1'b1) begin
      n_fail++;
      $display("FAIL overflow_fill: fill=%0d ovf=%b required 16/1", fill_out, ovf_out);
    end
    ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      n_cmp++;
      if (valid_out !== 1'b1 || l_out !== SW'(i) || r_out !== SW'(-i) ||
          m_out !== ref_mono(SW'(i), SW'(-i)) || fill_out !== 5'(DEPTH - i)) begin
        n_fail++;
        $display("FAIL drain_order[%0d]: v=%b l=%h r=%h m=%h fill=%0d required l=%h r=%h fill=%0d",
                 i, valid_out, l_out, r_out, m_out, fill_out, SW'(i), SW'(-i), DEPTH - i);
      end
      tick();
    end
    idle_inputs();
    n_cmp++;
    if (valid_out !== 1'b0 || fill_out !== 5'd0) begin
      n_fail++;
      $display("FAIL drain_empty: valid=%b fill=%0d required 0/0", valid_out, fill_out);
    end
    // Ready held while empty must not disturb anything.
    ready = 1'b1;
    tick(); tick();
    n_cmp++;
    if (valid_out !== 1'b0 || fill_out !== 5'd0) begin
      n_fail++;
      $display("FAIL empty_ready: valid=%b fill=%0d required 0/0", valid_out, fill_out);
    end
    idle_inputs();
  endtask

  task automatic test_full_pop_write();
    logic [SW-1:0] nl, nr;
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      l_in = SW'($urandom); r_in = SW'($urandom); strobe = 1'b1;
      tick();
    end
    nl = SW'($urandom); nr = SW'($urandom);
    l_in = nl; r_in = nr; strobe = 1'b1; ready = 1'b1;
    tick();
    strobe = 1'b0;
    n_cmp++;
    if (fill_out !== 5'd16 || ovf_out !== 1'b0 || fill_out !== 5'(mq.size())) begin
      n_fail++;
      $display("FAIL full_pop_write: fill=%0d ovf=%b required 16/0", fill_out, ovf_out);
    end
    for (int i = 0; i < DEPTH; i++) begin
      n_cmp++;
      if (l_out !== exp_l() || r_out !== exp_r() || valid_out !== 1'b1) begin
        n_fail++;
        $display("FAIL full_drain[%0d]: l=%h r=%h v=%b required l=%h r=%h", i, l_out, r_out, valid_out, exp_l(), exp_r());
      end
      if (i == DEPTH - 1) begin
        n_cmp++;
        if (l_out !== nl || r_out !== nr) begin
          n_fail++;
          $display("FAIL last_pair: l=%h r=%h required l=%h r=%h", l_out, r_out, nl, nr);
        end
      end
      tick();
    end
    idle_inputs();
  endtask

  task automatic test_random_stream();
    int sent = 0;
    int cyc  = 0;
    do_reset();
    while (sent < 1000 && cyc < 20000) begin
      strobe = ((cyc % 4) == 0);
      if (strobe) begin
        l_in = SW'($urandom); r_in = SW'($urandom); sent++;
      end
      ready = $urandom_range(0, 1) == 1;
      tick();
      cyc++;
      n_cmp++;
      if (valid_out !== (mq.size() != 0) || l_out !== exp_l() || r_out !== exp_r() ||
          m_out !== ref_mono(exp_l(), exp_r()) || fill_out !== 5'(mq.size()) || ovf_out !== m_ovf) begin
        n_fail++;
        $display("FAIL stream[%0d]: v=%b l=%h r=%h m=%h fill=%0d ovf=%b required v=%b l=%h r=%h fill=%0d ovf=%b",
                 cyc, valid_out, l_out, r_out, m_out, fill_out, ovf_out,
                 mq.size() != 0, exp_l(), exp_r(), mq.size(), m_ovf);
      end
    end
    n_cmp++;
    if (sent != 1000) begin
      n_fail++;
      $display("FAIL stream_budget: sent=%0d required 1000", sent);
    end
    idle_inputs();
  endtask

  task automatic test_overflow_clear();
    do_reset();
    for (int i = 0; i < DEPTH + 1; i++) begin
      l_in = SW'($urandom); r_in = SW'($urandom); strobe = 1'b1;
      tick();
    end
    strobe = 1'b0;
    n_cmp++;
    if (ovf_out !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_set: ovf=%b required 1", ovf_out);
    end
    strobe = 1'b1; clr = 1'b1;
    tick();
    strobe = 1'b0; clr = 1'b0;
    n_cmp++;
    if (ovf_out !== 1'b1 || ovf_out !== m_ovf) begin
      n_fail++;
      $display("FAIL drop_beats_clear: ovf=%b required 1", ovf_out);
    end
    clr = 1'b1;
    tick();
    clr = 1'b0;
    n_cmp++;
    if (ovf_out !== 1'b0 || fill_out !== 5'd16) begin
      n_fail++;
      $display("FAIL clear_alone: ovf=%b fill=%0d required 0/16", ovf_out, fill_out);
    end
    idle_inputs();
  endtask

  task automatic test_async_reset();
    logic [SW-1:0] fl, fr;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      l_in = SW'($urandom); r_in = SW'($urandom); strobe = 1'b1;
      tick();
    end
    idle_inputs();
    n_cmp++;
    if (fill_out !== 5'd5 || valid_out !== 1'b1) begin
      n_fail++;
      $display("FAIL pre_reset_fill: fill=%0d v=%b required 5/1", fill_out, valid_out);
    end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (valid_out !== 1'b0 || fill_out !== 5'd0 || ovf_out !== 1'b0 || l_out !== '0) begin
      n_fail++;
      $display("FAIL async_reset: v=%b fill=%0d ovf=%b l=%h required 0/0/0/0", valid_out, fill_out, ovf_out, l_out);
    end
    tick();
    #2 rst_n = 1'b1;
    tick();
    fl = SW'($urandom); fr = SW'($urandom);
    l_in = fl; r_in = fr; strobe = 1'b1;
    tick();
    strobe = 1'b0;
    n_cmp++;
    if (valid_out !== 1'b1 || l_out !== fl || r_out !== fr || fill_out !== 5'd1) begin
      n_fail++;
      $display("FAIL post_reset_first: v=%b l=%h r=%h fill=%0d required 1/%h/%h/1", valid_out, l_out, r_out, fill_out, fl, fr);
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_latency();
    test_fill_overflow_drain();
    test_full_pop_write();
    test_random_stream();
    test_overflow_clear();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
